// File: rtl/rom_prog_loader.sv
// rom_prog_loader: 16x10 RAM with async read port and a valid/ready burst loader (optional checksum via ROM_PROG_CHECKSUM_EN)
module rom_prog_loader #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] burst_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data
`ifdef ROM_PROG_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic take_start, accept;
  assign busy     = (state_q == LOAD);
  assign wr_ready = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign data     = mem_q[address];
  // next-state: capture burst on start in IDLE, count down accepted words in LOAD
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    take_start = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        take_start = 1'b1;
        state_d    = LOAD;
        ptr_d      = start_addr;
        cnt_d      = burst_len;
      end
      LOAD: if (wr_valid) begin
        accept  = 1'b1;
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = (cnt_q == '0) ? DONE : LOAD;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  // storage array: cleared on reset, written at the pointer on each accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[ptr_q] <= wr_data;
    end
  end
`ifdef ROM_PROG_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  assign csum_d   = take_start ? '0 : accept ? (csum_q ^ wr_data) : csum_q;
  assign checksum = csum_q;
  // running XOR of the words accepted in the current burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif
endmodule

// File: tb/tb_rom_prog_loader.sv
// tb_rom_prog_loader: directed bench with a word-level memory model checked every cycle
module tb_rom_prog_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_valid = 1'b0;
  logic [3:0] start_addr = '0, burst_len = '0, address = '0;
  logic [9:0] wr_data = '0;
  logic wr_ready, busy, done;
  logic [9:0] data;
`ifdef ROM_PROG_CHECKSUM_EN
  logic [9:0] checksum;
`endif
  int tests = 0, fails = 0, done_cnt = 0, acc_cnt = 0, mark;
  logic [9:0] m_mem [16];
  logic [9:0] m_ck;
  int m_addr, m_left;
  bit m_busy, m_done;

  always #5 clk = ~clk;

  rom_prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .burst_len(burst_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done(done),
    .address(address), .data(data)
`ifdef ROM_PROG_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  // model: a burst is a count of words written to consecutive addresses mod 16
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_addr = 0; m_left = 0; m_busy = 0; m_done = 0; m_ck = '0;
    end else if (m_done) m_done = 0;
    else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_addr = start_addr; m_left = burst_len + 1; m_ck = '0;
      end
    end else if (wr_valid) begin
      m_mem[m_addr] = wr_data;
      m_ck = m_ck ^ wr_data;
      m_addr = (m_addr + 1) % 16;
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_done = 1; end
    end
  end

  always @(posedge clk) if (!rst && wr_valid && wr_ready) acc_cnt++;

  always @(negedge clk) begin
    chk("data", data, m_mem[address]);
    chk("busy", busy, m_busy);
    chk("wr_ready", wr_ready, m_busy);
    chk("done", done, m_done);
`ifdef ROM_PROG_CHECKSUM_EN
    chk("checksum", checksum, m_ck);
`endif
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
    address = address + 4'd1;
  endtask

  task automatic do_start(input logic [3:0] sa, input logic [3:0] bl);
    start = 1; start_addr = sa; burst_len = bl;
    tick();
    start = 0;
  endtask

  task automatic feed(input logic [9:0] d);
    wr_valid = 1; wr_data = d;
    tick();
    wr_valid = 0;
  endtask

  task automatic rd(input string n, input logic [3:0] a, input logic [9:0] e);
    address = a; #1;
    chk(n, data, e);
  endtask

  initial begin
    repeat (2) tick();
    rst = 0;
    tick();
    for (int i = 0; i < 16; i++) begin
      address = 4'(i); #50;
      chk("reset_data", data, 10'h000);
    end
    chk("reset_busy", busy, 0);
    chk("reset_ready", wr_ready, 0);
    chk("reset_done", done, 0);

    do_start(4'd0, 4'd9);
    for (int i = 1; i <= 10; i++) feed(10'(i));
    chk("basic_done_pulse", done, 1);
    tick();
    chk("basic_done_drop", done, 0);
    tick();
    chk("basic_done_count", done_cnt, 1);
    for (int i = 0; i < 16; i++) rd("basic_mem", 4'(i), (i < 10) ? 10'(i + 1) : 10'h000);

    mark = acc_cnt;
    do_start(4'd14, 4'd3);
    feed(10'h3FF);
    feed(10'h155);
    for (int g = 0; g < 3; g++) begin
      start = (g == 1); start_addr = 4'd5; burst_len = 4'd0;
      tick();
      start = 0;
      chk("gap_busy", busy, 1);
    end
    feed(10'h2AA);
    feed(10'h0F0);
    tick(); tick();
    chk("wrap_writes", acc_cnt - mark, 4);
    rd("wrap_m14", 4'd14, 10'h3FF);
    rd("wrap_m15", 4'd15, 10'h155);
    rd("wrap_m0", 4'd0, 10'h2AA);
    rd("wrap_m1", 4'd1, 10'h0F0);
    rd("ignored_start_m5", 4'd5, 10'h006);

    mark = done_cnt;
    do_start(4'd3, 4'd7);
    feed(10'h011);
    feed(10'h022);
    rst = 1; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", wr_ready, 0);
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 16; i++) rd("midrst_mem", 4'(i), 10'h000);
    tick(); tick();
    chk("midrst_no_done", done_cnt - mark, 0);
    do_start(4'd0, 4'd0);
    feed(10'h123);
    tick(); tick();
    rd("after_rst_m0", 4'd0, 10'h123);

`ifdef ROM_PROG_CHECKSUM_EN
    do_start(4'd2, 4'd2);
    feed(10'h0F0);
    feed(10'h00F);
    feed(10'h3FF);
    tick(); tick();
    chk("checksum_val", checksum, 10'h300);
    do_start(4'd0, 4'd0);
    chk("checksum_clear", checksum, 10'h000);
    feed(10'h001);
    tick(); tick();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rom_prog_loader.md
Name: rom_prog_loader

Overview:
- Programmable 16 x 10 lookup memory with an asynchronous read port.
- The read port has the same contract as the existing combinational ROM: 4-bit address in, 10-bit data out. The block is a drop-in for read-side consumers.
- Adds the missing write side: a loader FSM accepts a burst of words over a valid/ready handshake and fills consecutive locations from a start address, wrapping at the top of the array.
- Used to program lookup contents at run time instead of fixing them at synthesis.

Parameters:
- DATA_W, 10, word width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a load burst; sampled only in IDLE.
- start_addr  in  ADDR_W  first write location, captured on an accepted start.
- burst_len  in  ADDR_W  burst length minus one (0 means 1 word, 15 means 16 words), captured on an accepted start.
- wr_valid  in  1  wr_data is valid this cycle.
- wr_data  in  DATA_W  word to write.
- wr_ready  out  1  loader accepts a word this cycle.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse after the last word of a burst is written.
- address  in  ADDR_W  read address.
- data  out  DATA_W  mem[address], combinational.

Behaviour:
- Reset values (asynchronous, immediate): FSM = IDLE; wr_ready = 0; busy = 0; done = 0; write pointer = 0; remaining count = 0; all 16 memory words = 0. Consequently data = 0 for every address during and after reset.
- FSM state IDLE:
  - busy = 0, wr_ready = 0.
  - If start = 1 at a clock edge: latch start_addr into the pointer, latch burst_len into the remaining count, go to LOAD.
- FSM state LOAD:
  - busy = 1, wr_ready = 1. wr_ready is a registered-state decode; it has no combinational path from wr_valid.
  - A word is accepted on an edge where wr_valid and wr_ready are both 1: mem[ptr] <= wr_data and ptr <= ptr + 1 modulo 16 (15 wraps to 0).
  - If the remaining count was 0 when the word was accepted, go to DONE. Otherwise decrement the count and stay in LOAD.
  - If wr_valid = 0, hold with no write; stalls of any length are allowed.
- FSM state DONE:
  - busy = 0, wr_ready = 0, done = 1 for exactly one cycle.
  - Next state is IDLE unconditionally.
  - start is ignored in DONE; the earliest restart is the cycle after DONE.
- start asserted while in LOAD or DONE: ignored, with no effect on the pointer or count.
- A 16-word burst overwrites every location once. The pointer ends at start_addr again.
- Read port:
  - Purely combinational from address and the memory array.
  - A word written at edge N is visible on data from just after edge N. This also holds mid-burst.
  - The read path is independent of the FSM state.
- Reset asserted mid-burst: abort immediately. Memory clears to 0, the FSM returns to IDLE, and no done pulse is produced.
- Write latency: 1 clock from the accept edge to memory. done rises 1 cycle after the final accept edge.

Optional Feature:
- Macro: ROM_PROG_CHECKSUM_EN
- Defined:
  - Adds output port checksum, DATA_W wide.
  - A running XOR of every word accepted in the current burst.
  - Cleared to 0 on an accepted start and on rst.
  - Updated on each accept edge and held after done.
- Undefined: the port and its logic are absent. Everything else is identical.

Test Plan:
- Reset check: assert rst, then release it; sweep address 0..15 (one address per 50 ns) -> data = 0x000 for all, busy = 0, wr_ready = 0, done = 0.
- Basic burst:
  - Stimulus: start with start_addr = 0 and burst_len = 9, then feed words 0x001..0x00A on consecutive cycles.
  - Required: done pulses once, 1 cycle after the 10th accept.
  - Required: reading address i gives i+1 for i = 0..9, and 0x000 for addresses 10..15.
- Wrap and stall:
  - Stimulus: start with start_addr = 14 and burst_len = 3, feeding 0x3FF, 0x155, 0x2AA, 0x0F0 with a 3-cycle wr_valid gap after the 2nd word.
  - Required: mem[14] = 0x3FF, mem[15] = 0x155, mem[0] = 0x2AA, mem[1] = 0x0F0.
  - Required: busy stays high through the gap and exactly 4 writes occur.
- Ignored start:
  - Stimulus: pulse start with start_addr = 5 in the middle of the burst above.
  - Required: the pointer and count are unaffected, and mem[5] is unchanged.
- Reset mid-burst:
  - Stimulus: assert rst after 2 of 8 words of a burst.
  - Required: busy drops immediately, all addresses read 0x000, and no done pulse occurs.
  - Required: a following start with start_addr = 0 and burst_len = 0, writing 0x123, gives mem[0] = 0x123.
- Checksum (ROM_PROG_CHECKSUM_EN defined):
  - Stimulus: a burst of 0x0F0, 0x00F, 0x3FF.
  - Required: checksum = 0x300 after done.
  - Required: checksum clears to 0 on the next accepted start.
